param_buffer_ctrl: RTL
======================

Name: param_buffer_ctrl

Overview:
- Sequences and shares the primitive parameter cache (1024-entry, 1-cycle-read BRAM bank addressed by a 12-bit prim_tag, single write strobe) between two requesters.
- The display-list parser writes primitives; the rasterizer/ISP reads them back by tag.
- Allocates tags sequentially per tile, tracks the committed entry count, arbitrates the single address port and flags out-of-range reads.
- Flushed at every tile start.

Parameters:
- TAG_W, 12, width of prim_tag / tag ports.
- ENTRIES, 1024, cache depth; tags 0..ENTRIES-1 valid.
- STARVE_MAX, 4, consecutive read grants allowed while a write waits before the write is forced through.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  tile-start pulse; discards all allocated entries.
- wr_req  in  1  parser has a primitive to store (held until wr_gnt).
- wr_gnt  out  1  combinational; write accepted this cycle.
- wr_tag  out  TAG_W  tag allocated to the accepted write; valid when wr_gnt=1.
- rd_req  in  1  rasterizer requests a primitive (held until rd_gnt or rd_err).
- rd_tag  in  TAG_W  tag to read.
- rd_gnt  out  1  combinational; read accepted this cycle.
- rd_err  out  1  combinational; rd_tag >= entry_count, request consumed, no read issued.
- rd_data_valid  out  1  registered; cache outputs hold the requested primitive.
- prim_tag  out  TAG_W  registered cache address.
- pcache_write  out  1  registered cache write strobe.
- entry_count  out  TAG_W  committed entries this tile.
- full  out  1  entry_count == ENTRIES.

Behaviour:
- Reset (reset_n=0 at a clock edge): entry_count=0, prim_tag=0, pcache_write=0, rd_data_valid=0, starve counter=0, pipeline cleared.
  - Combinational outputs are 0 while reset_n=0.
  - Reset mid-operation discards any in-flight read; rd_data_valid never asserts for it.
- Eligibility:
  - Write eligible: wr_req & ~full & ~flush.
  - Read eligible: rd_req & ~flush & (rd_tag < entry_count). Compare is unsigned; entry_count is zero-extended.
- rd_err: rd_req & ~flush & (rd_tag >= entry_count). Asserted without waiting for arbitration and without using the address port. rd_gnt stays 0.
- Arbitration per cycle:
  - Only one of read or write is granted.
  - Read wins by default.
  - If a write is eligible and starve_cnt == STARVE_MAX, the write wins.
  - starve_cnt increments on each read grant while a write is eligible but not granted.
  - starve_cnt resets to 0 on a write grant, or in any cycle with no eligible write.
- Write grant in cycle t:
  - wr_tag = entry_count[TAG_W-1:0].
  - Next edge: prim_tag <= wr_tag, pcache_write <= 1, entry_count <= entry_count+1.
  - pcache_write is a one-cycle pulse per grant. Back-to-back grants give consecutive tags.
- Read grant in cycle t:
  - Next edge: prim_tag <= rd_tag, pcache_write <= 0.
  - The cache registers the data at edge t+2.
  - rd_data_valid=1 during cycle t+2 only, via a 2-stage valid pipeline. Back-to-back reads give back-to-back valids.
- Idle cycle (no grant): prim_tag holds its value, pcache_write <= 0.
- A tag written at cycle t is readable from cycle t+1. This is safe: the read address is registered at t+2, after the write at t+1.
- Full: entry_count=ENTRIES, full=1, wr_gnt=0, and writes stall until flush. entry_count never wraps.
- Flush:
  - Highest priority. No grants in the flush cycle.
  - entry_count <= 0 and starve_cnt <= 0 at the next edge.
  - In-flight reads still complete: their rd_data_valid is not cancelled.
  - A pending write or read simply retries after the flush.

Test Plan:
- Reset then 3 writes on consecutive cycles, no reads → wr_tag 0,1,2; pcache_write pulses with prim_tag 0,1,2 one cycle later; entry_count=3.
- After 3 writes, read rd_tag=1 at cycle t → rd_gnt at t, prim_tag=1 at t+1, rd_data_valid only at t+2; rd_tag=3 → rd_err=1, no prim_tag change.
- rd_req and wr_req held together continuously, STARVE_MAX=4 → grant pattern R,R,R,R,W repeating; write tags increment once per 5 cycles.
- Write 1024 entries → full=1, entry_count=1024, 1025th wr_req never granted; flush pulse → next cycle full=0, entry_count=0, pending write granted with wr_tag=0.
- Flush coincident with wr_req and rd_req → no grant, no rd_err; a read granted the cycle before still gives rd_data_valid 2 cycles after its grant.
- reset_n low for one cycle between a read grant and its rd_data_valid → rd_data_valid stays 0; all outputs at reset values.

Source files
------------

// File: rtl/param_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// param_buffer_ctrl
//
// Sequences and shares the primitive parameter cache (one address port,
// one write strobe, 1-cycle read latency) between the display-list parser,
// which stores primitives, and the rasterizer/ISP, which reads them back
// by tag.
// Tags are handed out sequentially per tile. The cache is flushed at every
// tile start.
//
// Ports:
//   clock          single clock
//   reset_n        synchronous, active-low reset
//   flush          tile-start pulse; discards all allocated entries
//   wr_req         parser has a primitive to store (held until wr_gnt)
//   wr_gnt         combinational; write accepted this cycle
//   wr_tag         tag allocated to the accepted write (valid with wr_gnt)
//   rd_req         rasterizer read request (held until rd_gnt or rd_err)
//   rd_tag         tag to read
//   rd_gnt         combinational; read accepted this cycle
//   rd_err         combinational; rd_tag not yet allocated, request consumed
//   rd_data_valid  registered; cache outputs hold the requested primitive
//   prim_tag       registered cache address
//   pcache_write   registered cache write strobe
//   entry_count    committed entries this tile
//   full           entry_count == ENTRIES
// ---------------------------------------------------------------------------
module param_buffer_ctrl #(
  parameter int TAG_W      = 12,
  parameter int ENTRIES    = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             wr_req,
  output logic             wr_gnt,
  output logic [TAG_W-1:0] wr_tag,
  input  logic             rd_req,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_gnt,
  output logic             rd_err,
  output logic             rd_data_valid,
  output logic [TAG_W-1:0] prim_tag,
  output logic             pcache_write,
  output logic [TAG_W-1:0] entry_count,
  output logic             full
);

  localparam int              STARVE_W    = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [TAG_W-1:0]    ENTRIES_TAG = TAG_W'(ENTRIES);

  logic [STARVE_W-1:0] starve_cnt;
  logic                rd_in_range;
  logic                wr_elig;
  logic                rd_elig;
  logic                force_wr;
  logic                rd_valid_s1;

  assign full = (entry_count == ENTRIES_TAG);

  // Both operands are TAG_W wide, so this is a plain unsigned compare
  // against the zero-extended entry count.
  assign rd_in_range = (rd_tag < entry_count);

  // Every combinational output is qualified with reset_n so the requesters
  // see nothing accepted while the block is held in reset.
  always_comb begin
    wr_elig  = reset_n & wr_req & ~full & ~flush;
    rd_elig  = reset_n & rd_req & ~flush & rd_in_range;
    force_wr = wr_elig & (starve_cnt == STARVE_LIM);
  end

  // Reads win the shared address port unless a write has already been held
  // off for STARVE_MAX consecutive read grants. An out-of-range read never
  // touches the port, so it is reported immediately and never arbitrates.
  always_comb begin
    wr_gnt = wr_elig & (~rd_elig | force_wr);
    rd_gnt = rd_elig & ~force_wr;
    rd_err = reset_n & rd_req & ~flush & ~rd_in_range;
    wr_tag = reset_n ? entry_count : '0;
  end

  // Starvation counter: only counts reads that overtook a waiting write.
  // Any write grant, any cycle with no eligible write, and flush clear it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (flush || wr_gnt || !wr_elig) begin
      starve_cnt <= '0;
    end else if (rd_gnt) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Entry allocation. Flush and a write grant are mutually exclusive since
  // flush removes write eligibility. The full check in wr_elig keeps the
  // count from ever wrapping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      entry_count <= '0;
    end else if (flush) begin
      entry_count <= '0;
    end else if (wr_gnt) begin
      entry_count <= entry_count + TAG_W'(1);
    end
  end

  // Cache address and write strobe. The address holds on idle cycles so the
  // cache output stays stable; the strobe is a one-cycle pulse per grant.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prim_tag     <= '0;
      pcache_write <= 1'b0;
    end else begin
      pcache_write <= wr_gnt;
      if (wr_gnt) begin
        prim_tag <= wr_tag;
      end else if (rd_gnt) begin
        prim_tag <= rd_tag;
      end
    end
  end

  // Read-valid pipeline: stage 1 marks the cycle the address is registered,
  // stage 2 the cycle the cache output holds the data. Flush deliberately
  // leaves this alone so reads already issued still complete; only reset
  // cancels them.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_valid_s1   <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_valid_s1   <= rd_gnt;
      rd_data_valid <= rd_valid_s1;
    end
  end

endmodule
